// File: rtl/bf_sequencer_if.sv
// Handshake and status bundle between the run sequencer and the
// update feed, relax datapath and cycle-detect datapath.
interface bf_sequencer_if #(
    parameter int PASS_W = 4
);
    logic              start;
    logic              upd_valid;
    logic              upd_ready;
    logic              init_en;
    logic              relax_reset;
    logic              relax_done;
    logic              cycle_reset;
    logic              cycle_done;
    logic              busy;
    logic              done;
    logic [PASS_W-1:0] pass_cnt;
    logic [15:0]       run_cnt;
    logic              timeout;

    modport master (
        input  start, upd_valid, relax_done, cycle_done,
        output upd_ready, init_en, relax_reset, cycle_reset,
        output busy, done, pass_cnt, run_cnt, timeout
    );

    modport slave (
        output start, upd_valid, relax_done, cycle_done,
        input  upd_ready, init_en, relax_reset, cycle_reset,
        input  busy, done, pass_cnt, run_cnt, timeout
    );
endinterface

// File: rtl/bf_sequencer.sv
// Bellman-Ford run controller: init, NODES-1 relax passes, one
// negative-cycle sweep, with edge-update arbitration and a watchdog.
module bf_sequencer #(
    parameter int NODES       = 8,
    parameter int PASS_W      = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          clk,
    input  logic          reset,
    bf_sequencer_if.master bus
);
    localparam int WD_W =
        (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'(TIMEOUT_CYC - 1);
    localparam logic [PASS_W-1:0] PASS_LAST =
        PASS_W'(NODES - 1);

    typedef enum logic [2:0] {
        IDLE, INIT, RELAX_GO, RELAX_WAIT,
        CYC_GO, CYC_WAIT, FINISH, ERROR
    } state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [15:0]       run_q, run_d;

    logic upd_ready_q, upd_ready_d;
    logic init_q, init_d;
    logic rrst_q, rrst_d;
    logic crst_q, crst_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic tmo_q, tmo_d;

    logic blank, wd_hit, relax_ok, cyc_ok, last_pass;

    // wdog==0 is the blanking cycle right after a GO pulse
    assign blank     = (wdog_q == '0);
    assign wd_hit    = (wdog_q == WD_LAST);
    assign relax_ok  = bus.relax_done & ~blank;
    assign cyc_ok    = bus.cycle_done & ~blank;
    assign last_pass = ((pass_q + PASS_W'(1)) == PASS_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            wdog_q  <= '0;
            pass_q  <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wdog_q  <= wdog_d;
            pass_q  <= pass_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        wdog_d  = wdog_q;
        pass_d  = pass_q;
        run_d   = run_q;
        if (bus.start && state_q != IDLE && state_q != ERROR)
            pend_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (bus.upd_valid) begin
                    if (bus.start) pend_d = 1'b1;
                end else if (bus.start || pend_q) begin
                    state_d = INIT;
                    pend_d  = 1'b0;
                end
            end
            INIT: begin
                pass_d  = '0;
                state_d = RELAX_GO;
            end
            RELAX_GO: begin
                wdog_d  = '0;
                state_d = RELAX_WAIT;
            end
            RELAX_WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                if (relax_ok) begin
                    pass_d  = pass_q + PASS_W'(1);
                    state_d = last_pass ? CYC_GO : RELAX_GO;
                end else if (wd_hit) begin
                    state_d = ERROR;
                end
            end
            CYC_GO: begin
                wdog_d  = '0;
                state_d = CYC_WAIT;
            end
            CYC_WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                if (cyc_ok) begin
                    run_d   = run_q + 16'd1;
                    state_d = FINISH;
                end else if (wd_hit) begin
                    state_d = ERROR;
                end
            end
            FINISH:  state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the state being entered so they leave a flop
    always_comb begin
        upd_ready_d = (state_d == IDLE);
        init_d      = (state_d == INIT);
        rrst_d      = (state_d == RELAX_GO);
        crst_d      = (state_d == CYC_GO);
        done_d      = (state_d == FINISH);
        tmo_d       = (state_d == ERROR);
        busy_d      = (state_d != IDLE) && (state_d != ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_ready_q <= 1'b1;
            init_q      <= 1'b0;
            rrst_q      <= 1'b0;
            crst_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            upd_ready_q <= upd_ready_d;
            init_q      <= init_d;
            rrst_q      <= rrst_d;
            crst_q      <= crst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.upd_ready   = upd_ready_q;
    assign bus.init_en     = init_q;
    assign bus.relax_reset = rrst_q;
    assign bus.cycle_reset = crst_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = tmo_q;
    assign bus.pass_cnt    = pass_q;
    assign bus.run_cnt     = run_q;
endmodule

// File: tb/tb_bf_sequencer.sv
// Bench for bf_sequencer: timestamp-based reference model compared
// every cycle, plus directed scenarios with hand-computed timings.
module tb_bf_sequencer;
    localparam int NODES  = 4;
    localparam int PASS_W = 4;
    localparam int TMO    = 100;
    localparam int RLAT   = 10;
    localparam int CLAT   = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bf_sequencer_if #(.PASS_W(PASS_W)) bus();

    bf_sequencer #(
        .NODES(NODES),
        .PASS_W(PASS_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int     n_assert = 0;
    int     n_fail = 0;
    longint cyc = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (event timestamps) ----------
    bit     m_busy, m_err, m_pend, m_wr, m_wc;
    int     m_pass, m_run;
    longint m_init, m_rgo, m_cgo, m_fin;

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_pend = 0; m_wr = 0; m_wc = 0;
        m_pass = 0; m_run = 0;
        m_init = -9; m_rgo = -9; m_cgo = -9; m_fin = -9;
    endtask

    task automatic model_step();
        longint t;
        t = cyc;
        cyc = cyc + 1;
        if (!m_busy) begin
            if (!m_err) begin
                if (bus.upd_valid) begin
                    if (bus.start) m_pend = 1;
                end else if (bus.start || m_pend) begin
                    m_busy = 1; m_pend = 0;
                    m_init = t + 1; m_rgo = t + 2;
                end
            end
        end else begin
            if (bus.start) m_pend = 1;
            if (t == m_init) m_pass = 0;
            if (t == m_rgo) m_wr = 1;
            else if (m_wr) begin
                if (bus.relax_done && t > m_rgo + 1) begin
                    m_wr = 0;
                    m_pass = m_pass + 1;
                    if (m_pass == NODES - 1) m_cgo = t + 1;
                    else m_rgo = t + 1;
                end else if (t - m_rgo == TMO) begin
                    m_err = 1; m_busy = 0; m_wr = 0;
                end
            end
            if (t == m_cgo) m_wc = 1;
            else if (m_wc) begin
                if (bus.cycle_done && t > m_cgo + 1) begin
                    m_wc = 0;
                    m_fin = t + 1;
                    m_run = (m_run + 1) & 16'hFFFF;
                end else if (t - m_cgo == TMO) begin
                    m_err = 1; m_busy = 0; m_wc = 0;
                end
            end
            if (t == m_fin) m_busy = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare + event log ---------------
    int     n_init = 0, n_rgo = 0, n_cgo = 0, n_done = 0;
    longint t_tmo = -1;
    bit     prev_tmo = 0;

    initial begin
        forever begin
            @(negedge clk);
            chk("init_en", bus.init_en, cyc == m_init);
            chk("relax_reset", bus.relax_reset, cyc == m_rgo);
            chk("cycle_reset", bus.cycle_reset, cyc == m_cgo);
            chk("done", bus.done, cyc == m_fin);
            chk("busy", bus.busy, m_busy);
            chk("upd_ready", bus.upd_ready, !m_busy && !m_err);
            chk("timeout", bus.timeout, m_err);
            chk("pass_cnt", bus.pass_cnt, m_pass);
            chk("run_cnt", bus.run_cnt, m_run);
            if (bus.init_en) n_init++;
            if (bus.relax_reset) n_rgo++;
            if (bus.cycle_reset) n_cgo++;
            if (bus.done) n_done++;
            if (bus.timeout && !prev_tmo) t_tmo = cyc;
            prev_tmo = bus.timeout;
        end
    end

    // ---------------- datapath responders -------------------------
    bit rnever = 0, rstale = 0;
    int rage = 0, cage = 0;
    bit rarm = 0, carm = 0;

    initial begin
        bus.relax_done = 0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                bus.relax_done = 0; rarm = 0;
            end else if (bus.relax_reset) begin
                if (!rstale) bus.relax_done = 0;
                rarm = !rnever; rage = 0;
            end else if (rarm) begin
                rage++;
                if (rage == 2) bus.relax_done = 0;
                if (rage == RLAT) begin
                    bus.relax_done = 1; rarm = 0;
                end
            end
        end
    end

    initial begin
        bus.cycle_done = 0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                bus.cycle_done = 0; carm = 0;
            end else if (bus.cycle_reset) begin
                bus.cycle_done = 0; carm = 1; cage = 0;
            end else if (carm) begin
                cage++;
                if (cage == CLAT) begin
                    bus.cycle_done = 1; carm = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------
    function automatic bit sel(input int w);
        case (w)
            0: return bus.init_en;
            1: return bus.relax_reset;
            2: return bus.cycle_reset;
            3: return bus.done;
            default: return bus.timeout;
        endcase
    endfunction

    task automatic wait_for(input string name, input int w,
                            input int maxc, output longint at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (sel(w)) begin
                at = cyc;
                break;
            end
        end
        n_assert++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL wait_%s: not seen within %0d cycles",
                     name, maxc);
        end
    endtask

    task automatic pulse_start(output longint s);
        @(posedge clk); #1;
        bus.start = 1;
        s = cyc;
        @(posedge clk); #1;
        bus.start = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not end");
        $fatal(1, "time limit");
    end

    // ---------------- directed scenarios --------------------------
    initial begin
        longint s, t, t2, tg, td1, d;
        int     b_init, b_rgo, b_cgo, b_done;
        bus.start = 0;
        bus.upd_valid = 0;
        reset = 1;
        repeat (3) @(negedge clk);
        chk("rst_upd_ready", bus.upd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_run_cnt", bus.run_cnt, 0);
        chk("rst_timeout", bus.timeout, 0);
        @(posedge clk); #1;
        reset = 0;
        repeat (2) @(posedge clk);

        // 1: single run, 10/20-cycle datapath latencies
        b_rgo = n_rgo; b_cgo = n_cgo; b_done = n_done;
        pulse_start(s);
        wait_for("init", 0, 10, t);
        chk("t1_init_lat", t - s, 1);
        wait_for("rgo", 1, 10, t);
        chk("t1_rgo_lat", t - s, 2);
        wait_for("done", 3, 200, t);
        chk("t1_run_len", t - s, 56);
        repeat (10) @(negedge clk);
        chk("t1_n_relax", n_rgo - b_rgo, 3);
        chk("t1_n_cyc", n_cgo - b_cgo, 1);
        chk("t1_n_done", n_done - b_done, 1);
        chk("t1_pass_cnt", bus.pass_cnt, 3);
        chk("t1_run_cnt", bus.run_cnt, 1);

        // 2: start during run queues one extra run, third dropped
        b_init = n_init; b_done = n_done;
        pulse_start(s);
        wait_for("rgo", 1, 10, t);
        repeat (3) @(posedge clk);
        pulse_start(t);
        repeat (4) @(posedge clk);
        pulse_start(t);
        wait_for("done", 3, 200, td1);
        wait_for("init", 0, 10, t);
        chk("t2_pend_init", t - td1, 2);
        wait_for("done", 3, 200, t2);
        chk("t2_run2_len", t2 - td1, 57);
        repeat (80) @(negedge clk);
        chk("t2_n_init", n_init - b_init, 2);
        chk("t2_n_done", n_done - b_done, 2);
        chk("t2_run_cnt", bus.run_cnt, 3);

        // 3: update wins over start, then stalls during the run
        @(posedge clk); #1;
        bus.start = 1; bus.upd_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_upd_ready_idle", bus.upd_ready, 1);
        end
        @(posedge clk); #1;
        bus.start = 0; bus.upd_valid = 0;
        d = cyc;
        wait_for("init", 0, 10, t);
        chk("t3_init_after_drop", t - d, 1);
        @(posedge clk); #1;
        bus.upd_valid = 1;
        repeat (5) @(negedge clk);
        chk("t3_upd_ready_run", bus.upd_ready, 0);
        wait_for("done", 3, 200, t);
        @(negedge clk);
        chk("t3_upd_ready_back", bus.upd_ready, 1);
        @(posedge clk); #1;
        bus.upd_valid = 0;
        repeat (3) @(posedge clk);

        // 5: stale relax_done across GO is ignored in blanking
        rstale = 1;
        pulse_start(s);
        while (cyc < s + 4) @(negedge clk);
        chk("t5_blank_pass", bus.pass_cnt, 0);
        wait_for("done", 3, 200, t);
        chk("t5_run_len", t - s, 56);
        chk("t5_run_cnt", bus.run_cnt, 5);
        @(posedge clk); #1;
        rstale = 0;
        repeat (3) @(posedge clk);

        // 4: relax_done never arrives -> sticky timeout
        rnever = 1;
        pulse_start(s);
        wait_for("rgo", 1, 10, tg);
        wait_for("timeout", 4, TMO + 20, t);
        chk("t4_tmo_lat", t - tg, TMO + 1);
        chk("t4_busy", bus.busy, 0);
        chk("t4_upd_ready", bus.upd_ready, 0);
        b_init = n_init;
        pulse_start(s);
        repeat (6) @(negedge clk);
        chk("t4_start_ignored", n_init - b_init, 0);
        chk("t4_sticky", bus.timeout, 1);
        @(posedge clk); #3;
        reset = 1;
        #1;
        chk("t4_rst_timeout", bus.timeout, 0);
        chk("t4_rst_upd_ready", bus.upd_ready, 1);
        @(posedge clk); #1;
        reset = 0;
        rnever = 0;
        repeat (2) @(posedge clk);

        // 6: async reset mid CYC_WAIT, then a clean run
        pulse_start(s);
        wait_for("cgo", 2, 100, t);
        repeat (5) @(posedge clk);
        #3;
        reset = 1;
        #1;
        chk("t6_busy", bus.busy, 0);
        chk("t6_upd_ready", bus.upd_ready, 1);
        chk("t6_run_cnt", bus.run_cnt, 0);
        chk("t6_pass_cnt", bus.pass_cnt, 0);
        chk("t6_cycle_reset", bus.cycle_reset, 0);
        @(posedge clk); #1;
        reset = 0;
        repeat (2) @(posedge clk);
        pulse_start(s);
        wait_for("done", 3, 200, t);
        chk("t6_run_len", t - s, 56);
        @(negedge clk);
        chk("t6_run_cnt_after", bus.run_cnt, 1);
        chk("t6_pass_cnt_after", bus.pass_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
